// File: rtl/axis_wb_req_framer_if.sv
// Command port and byte-wide request stream of the AXI-stream-to-Wishbone request framer.
// The framer side uses the master modport; whoever issues commands and sinks the stream uses slave.
interface axis_wb_req_framer_if #(
    parameter int AXIS_DATA_WIDTH = 8,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int WB_DATA_WIDTH   = 32,
    parameter int WB_ADDR_WIDTH   = 32
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [15:0]                cmd_tag;
    logic [WB_ADDR_WIDTH-1:0]   cmd_addr;
    logic [WB_DATA_WIDTH-1:0]   cmd_wdata;

    logic [AXIS_DATA_WIDTH-1:0] output_axis_tdata;
    logic [AXIS_KEEP_WIDTH-1:0] output_axis_tkeep;
    logic                       output_axis_tvalid;
    logic                       output_axis_tready;
    logic                       output_axis_tlast;
    logic                       output_axis_tuser;

    logic                       busy;

    modport master (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_write,
        input  cmd_tag,
        input  cmd_addr,
        input  cmd_wdata,
        output output_axis_tdata,
        output output_axis_tkeep,
        output output_axis_tvalid,
        input  output_axis_tready,
        output output_axis_tlast,
        output output_axis_tuser,
        output busy
    );

    modport slave (
        output cmd_valid,
        input  cmd_ready,
        output cmd_write,
        output cmd_tag,
        output cmd_addr,
        output cmd_wdata,
        input  output_axis_tdata,
        input  output_axis_tkeep,
        input  output_axis_tvalid,
        output output_axis_tready,
        input  output_axis_tlast,
        input  output_axis_tuser,
        input  busy
    );
endinterface

// File: rtl/axis_wb_req_framer.sv
// Serializes single-word Wishbone read/write commands into byte-wide request frames:
// type, tag, address, count (=1) and, for writes, the data word, all fields MSB first.
module axis_wb_req_framer #(
    parameter int         AXIS_DATA_WIDTH = 8,
    parameter int         AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int         WB_DATA_WIDTH   = 32,
    parameter int         WB_ADDR_WIDTH   = 32,
    parameter int         COUNT_SIZE      = 16,
    parameter logic [7:0] READ_REQ        = 8'hA1,
    parameter logic [7:0] WRITE_REQ       = 8'hA2
) (
    input  logic                clock,
    input  logic                reset,
    axis_wb_req_framer_if.master bus
);

    localparam int TAG_BYTES   = 2;
    localparam int ADDR_BYTES  = WB_ADDR_WIDTH / 8;
    localparam int DATA_BYTES  = WB_DATA_WIDTH / 8;
    localparam int COUNT_BYTES = COUNT_SIZE / 8;

    function automatic int max_field_bytes();
        int m;
        m = TAG_BYTES;
        if (ADDR_BYTES > m) m = ADDR_BYTES;
        if (DATA_BYTES > m) m = DATA_BYTES;
        if (COUNT_BYTES > m) m = COUNT_BYTES;
        return m;
    endfunction

    localparam int MAX_BYTES = max_field_bytes();
    localparam int CNT_W     = $clog2(MAX_BYTES);

    generate
        if (AXIS_DATA_WIDTH != 8) begin : g_bad_axis_width
            $error("axis_wb_req_framer: only AXIS_DATA_WIDTH = 8 is supported");
        end
        if (WB_DATA_WIDTH != 8 && WB_DATA_WIDTH != 16 &&
            WB_DATA_WIDTH != 32 && WB_DATA_WIDTH != 64) begin : g_bad_data_width
            $error("axis_wb_req_framer: WB_DATA_WIDTH must be 8, 16, 32 or 64");
        end
        if (WB_ADDR_WIDTH < 8 || (WB_ADDR_WIDTH % 8) != 0) begin : g_bad_addr_width
            $error("axis_wb_req_framer: WB_ADDR_WIDTH must be a non-zero multiple of 8");
        end
        if (COUNT_SIZE < 8 || (COUNT_SIZE % 8) != 0) begin : g_bad_count_width
            $error("axis_wb_req_framer: COUNT_SIZE must be a non-zero multiple of 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_TYPE,
        S_TAG,
        S_ADDR,
        S_COUNT,
        S_DATA
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_n;

    logic                     write_r;
    logic [15:0]              tag_sh;
    logic [WB_ADDR_WIDTH-1:0] addr_sh;
    logic [WB_DATA_WIDTH-1:0] data_sh;

    logic                     tvalid;
    logic                     accept;
    logic                     beat;
    logic                     field_last;
    logic [7:0]               byte_out;
    logic                     last_out;

    function automatic state_t next_field(input state_t cur, input logic is_write);
        case (cur)
            S_TYPE:  return S_TAG;
            S_TAG:   return S_ADDR;
            S_ADDR:  return S_COUNT;
            S_COUNT: return is_write ? S_DATA : S_IDLE;
            default: return S_IDLE;
        endcase
    endfunction

    assign tvalid        = (state != S_IDLE);
    assign bus.cmd_ready = (state == S_IDLE) && !reset;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign beat          = tvalid && bus.output_axis_tready;

    always_comb begin
        field_last = 1'b0;
        case (state)
            S_TYPE:  field_last = 1'b1;
            S_TAG:   field_last = (cnt == CNT_W'(TAG_BYTES - 1));
            S_ADDR:  field_last = (cnt == CNT_W'(ADDR_BYTES - 1));
            S_COUNT: field_last = (cnt == CNT_W'(COUNT_BYTES - 1));
            S_DATA:  field_last = (cnt == CNT_W'(DATA_BYTES - 1));
            default: field_last = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == S_IDLE) begin
            if (accept) begin
                state_n = S_TYPE;
                cnt_n   = '0;
            end
        end else if (beat) begin
            if (field_last) begin
                state_n = next_field(state, write_r);
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    // Field registers shift left one byte per accepted beat so the head byte is always on top.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            write_r <= 1'b0;
            tag_sh  <= '0;
            addr_sh <= '0;
            data_sh <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                write_r <= bus.cmd_write;
                tag_sh  <= bus.cmd_tag;
                addr_sh <= bus.cmd_addr;
                data_sh <= bus.cmd_wdata;
            end else if (beat) begin
                case (state)
                    S_TAG:   tag_sh  <= tag_sh << 8;
                    S_ADDR:  addr_sh <= addr_sh << 8;
                    S_DATA:  data_sh <= data_sh << 8;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        byte_out = 8'h00;
        case (state)
            S_TYPE:  byte_out = write_r ? WRITE_REQ : READ_REQ;
            S_TAG:   byte_out = tag_sh[15:8];
            S_ADDR:  byte_out = addr_sh[WB_ADDR_WIDTH-1 -: 8];
            S_COUNT: byte_out = (cnt == CNT_W'(COUNT_BYTES - 1)) ? 8'h01 : 8'h00;
            S_DATA:  byte_out = data_sh[WB_DATA_WIDTH-1 -: 8];
            default: byte_out = 8'h00;
        endcase
    end

    // Reads end on the last count byte, writes on the last data byte.
    assign last_out = field_last &&
                      (((state == S_COUNT) && !write_r) || (state == S_DATA));

    assign bus.output_axis_tdata  = byte_out;
    assign bus.output_axis_tkeep  = tvalid ? {AXIS_KEEP_WIDTH{1'b1}} : {AXIS_KEEP_WIDTH{1'b0}};
    assign bus.output_axis_tvalid = tvalid;
    assign bus.output_axis_tlast  = last_out;
    assign bus.output_axis_tuser  = 1'b0;
    assign bus.busy               = tvalid;

endmodule

// File: tb/tb_axis_wb_req_framer.sv
// Directed bench for axis_wb_req_framer: frames expected at command acceptance are queued
// and compared byte by byte as the stream delivers them.
module tb_axis_wb_req_framer;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    axis_wb_req_framer_if #(
        .AXIS_DATA_WIDTH(8),
        .WB_DATA_WIDTH  (DW),
        .WB_ADDR_WIDTH  (AW)
    ) bus ();

    axis_wb_req_framer #(
        .AXIS_DATA_WIDTH(8),
        .WB_DATA_WIDTH  (DW),
        .WB_ADDR_WIDTH  (AW),
        .COUNT_SIZE     (16),
        .READ_REQ       (8'hA1),
        .WRITE_REQ      (8'hA2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];

    int   compared    = 0;
    int   mismatched  = 0;
    int   cyc         = 0;
    int   accept_cyc  = -100;
    int   first_cyc   = -100;
    int   last_cyc    = -100;
    int   busy_cycles = 0;
    int   total_beats = 0;
    logic stalled_prev = 1'b0;
    logic prev_tvalid  = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic prev_last    = 1'b0;
    logic bp_mode      = 1'b0;
    logic accepted     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic w, input logic [15:0] t,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [7:0] b[$];
        b.push_back(w ? 8'hA2 : 8'hA1);
        b.push_back(t[15:8]);
        b.push_back(t[7:0]);
        for (int i = AW/8 - 1; i >= 0; i--) b.push_back(a[8*i +: 8]);
        b.push_back(8'h00);
        b.push_back(8'h01);
        if (w) for (int i = DW/8 - 1; i >= 0; i--) b.push_back(d[8*i +: 8]);
        for (int i = 0; i < b.size(); i++) sb.push_back('{data: b[i], last: (i == b.size() - 1)});
    endtask

    // Looks at what the DUT presents to the coming rising edge.
    task automatic monitor();
        exp_t e;
        accepted = 1'b0;
        if (reset) begin
            chk("cmd_ready_in_reset", bus.cmd_ready, 0);
            stalled_prev = 1'b0;
            prev_tvalid  = 1'b0;
        end else begin
            chk("cmd_ready_vs_busy", bus.cmd_ready, !bus.busy);
            if (bus.output_axis_tvalid) begin
                if (!prev_tvalid) begin
                    chk("first_byte_latency", cyc, accept_cyc + 1);
                    first_cyc = cyc;
                end
                chk("tkeep_valid", bus.output_axis_tkeep, 1);
                if (stalled_prev) begin
                    chk("stall_tdata", bus.output_axis_tdata, prev_data);
                    chk("stall_tlast", bus.output_axis_tlast, prev_last);
                end
                if (bus.output_axis_tready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat_queue_depth", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("tdata", bus.output_axis_tdata, e.data);
                        chk("tlast", bus.output_axis_tlast, e.last);
                        if (e.last) last_cyc = cyc;
                    end
                    total_beats++;
                end
                stalled_prev = !bus.output_axis_tready;
                prev_data    = bus.output_axis_tdata;
                prev_last    = bus.output_axis_tlast;
            end else begin
                chk("idle_tlast", bus.output_axis_tlast, 0);
                chk("idle_tkeep", bus.output_axis_tkeep, 0);
                chk("idle_tdata", bus.output_axis_tdata, 0);
                stalled_prev = 1'b0;
            end
            prev_tvalid = bus.output_axis_tvalid;
            if (bus.busy) busy_cycles++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                push_frame(bus.cmd_write, bus.cmd_tag, bus.cmd_addr, bus.cmd_wdata);
                accept_cyc  = cyc;
                accepted    = 1'b1;
                busy_cycles = 0;
            end
        end
        chk("tuser", bus.output_axis_tuser, 0);
        cyc++;
    endtask

    task automatic tick();
        if (bp_mode) bus.output_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        #1;
        monitor();
        @(negedge clock);
    endtask

    task automatic send_cmd(input logic w, input logic [15:0] t, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit hold);
        int n;
        n = 0;
        bus.cmd_write = w;
        bus.cmd_tag   = t;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!accepted && n < 60);
        chk("cmd_accept_in_time", accepted, 1);
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 200) begin
            tick();
            n++;
        end
        chk("frame_drained", sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, bus.output_axis_tvalid, 0);
        chk({tag, "_tlast"}, bus.output_axis_tlast, 0);
        chk({tag, "_tkeep"}, bus.output_axis_tkeep, 0);
        chk({tag, "_tdata"}, bus.output_axis_tdata, 0);
        chk({tag, "_tuser"}, bus.output_axis_tuser, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        int lc1;
        int b0;
        int n;
        reset                  = 1'b1;
        bus.cmd_valid          = 1'b0;
        bus.cmd_write          = 1'b0;
        bus.cmd_tag            = '0;
        bus.cmd_addr           = '0;
        bus.cmd_wdata          = '0;
        bus.output_axis_tready = 1'b1;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset_outputs("reset_hold");
            chk("reset_hold_cmd_ready", bus.cmd_ready, 0);
        end
        reset = 1'b0;
        #1;
        chk("cmd_ready_after_reset", bus.cmd_ready, 1);
        tick();

        // Read, continuous tready
        send_cmd(1'b0, 16'h1234, 32'h0000_1000, 32'h0, 1'b0);
        wait_done();
        chk("read_busy_cycles", busy_cycles, 9);
        chk("read_span", last_cyc - first_cyc, 8);

        // Write, continuous tready
        send_cmd(1'b1, 16'hBEEF, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
        wait_done();
        chk("write_busy_cycles", busy_cycles, 13);
        chk("write_span", last_cyc - first_cyc, 12);
        tick();

        // Same write under tready 1,0,0,1 backpressure
        bp_mode = 1'b1;
        send_cmd(1'b1, 16'hBEEF, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
        wait_done();
        bp_mode = 1'b0;
        bus.output_axis_tready = 1'b1;
        chk("bp_stretched", (busy_cycles > 13), 1);
        tick();

        // Back-to-back: read then write with cmd_valid held high
        send_cmd(1'b0, 16'h0A0B, 32'h0000_2000, 32'h0, 1'b1);
        send_cmd(1'b1, 16'hC0DE, 32'h1234_5678, 32'hCAFE_F00D, 1'b0);
        lc1 = last_cyc;
        wait_done();
        chk("b2b_gap", first_cyc - lc1, 2);
        chk("b2b_write_busy", busy_cycles, 13);
        tick();

        // Reset after the fifth byte of a write
        send_cmd(1'b1, 16'h7777, 32'hA5A5_0000, 32'h0102_0304, 1'b0);
        b0 = total_beats;
        n  = 0;
        while ((total_beats - b0) < 5 && n < 50) begin
            tick();
            n++;
        end
        chk("five_beats_before_reset", total_beats - b0, 5);
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        chk_reset_outputs("mid_frame_reset");
        for (int i = 0; i < 3; i++) tick();
        send_cmd(1'b0, 16'h5555, 32'h1234_5678, 32'h0, 1'b0);
        wait_done();
        chk("post_reset_read_busy", busy_cycles, 9);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
